// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the game control blocks: the timekeeper
// FSM state encoding, the game_time width, and the level sequencer's types.
// No ports; imported by game_timekeeper, its interface and its sub-modules.
// ----------------------------------------------------------------------------
package game_pkg;

    // Level time width and its saturation value
    localparam int GAME_TIME_W = 11;
    localparam logic [GAME_TIME_W-1:0] GAME_TIME_MAX = 11'd2047;

    // Timekeeper FSM states
    typedef enum logic [1:0] {
        TK_IDLE    = 2'd0,
        TK_RUN     = 2'd1,
        TK_RESPAWN = 2'd2,
        TK_FROZEN  = 2'd3
    } tk_state_e;

    // Level sequencer states (owned by the level sequencer, shared here)
    typedef enum logic [1:0] {
        LVL_MENU = 2'd0,
        LVL_PLAY = 2'd1,
        LVL_WIN  = 2'd2,
        LVL_LOSE = 2'd3
    } level_state_e;

    // Saturating increment of the level time: sticks at GAME_TIME_MAX
    function automatic logic [GAME_TIME_W-1:0] sat_inc_time(
        input logic [GAME_TIME_W-1:0] t
    );
        logic [GAME_TIME_W-1:0] r;
        if (t == GAME_TIME_MAX) begin
            r = t;
        end else begin
            r = t + 11'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/game_timekeeper_if.sv
// ----------------------------------------------------------------------------
// game_timekeeper_if
// Signal bundle between the level sequencer / video timing side and the
// timekeeper.
//   frame_tick  : one-cycle pulse per display frame
//   playerDied  : collision indication (may be held several cycles)
//   menuScreen  : level sequencer is in menu
//   winScreen   : level sequencer is showing the win screen
//   game_time   : level time in units
//   userSel     : one-cycle pulse per debounced button press
//   respawning  : high during the post-death freeze
//   running     : high while game_time advances
// Modports: slave = timekeeper, master = sequencer / environment.
// ----------------------------------------------------------------------------
interface game_timekeeper_if;
    import game_pkg::*;

    logic                   frame_tick;
    logic                   playerDied;
    logic                   menuScreen;
    logic                   winScreen;
    logic [GAME_TIME_W-1:0] game_time;
    logic                   userSel;
    logic                   respawning;
    logic                   running;

    modport slave (
        input  frame_tick,
        input  playerDied,
        input  menuScreen,
        input  winScreen,
        output game_time,
        output userSel,
        output respawning,
        output running
    );

    modport master (
        output frame_tick,
        output playerDied,
        output menuScreen,
        output winScreen,
        input  game_time,
        input  userSel,
        input  respawning,
        input  running
    );

endinterface

// File: rtl/game_timekeeper_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer, counter debouncer and rising-edge pulse generator
// for an asynchronous active-high push button.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   btn_raw   : raw button, asynchronous to clk
//   btn_press : one-cycle pulse per accepted press (registered)
// After reset the debouncer is disarmed: a button already held through reset
// produces no pulse. It arms once the button has been seen released (either
// DEBOUNCE_CYCLES stable low cycles or an accepted 1->0 transition).
// ----------------------------------------------------------------------------
module btn_debounce
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [1:0]       prime_r;
    logic             level_r;
    logic             level_d_r;
    logic [CNT_W-1:0] cnt_r;
    logic             armed_r;
    logic [CNT_W-1:0] arm_cnt_r;
    logic             press_r;

    logic             level_nx_s;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             armed_nx_s;
    logic [CNT_W-1:0] arm_cnt_nx_s;

    // Synchronizer chain; prime_r marks when sync2_r carries a real sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prime_r <= 2'b00;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            prime_r <= {prime_r[0], 1'b1};
        end
    end

    // Debounce: flip the accepted level after DEBOUNCE_CYCLES differing cycles
    always_comb begin
        level_nx_s = level_r;
        cnt_nx_s   = {CNT_W{1'b0}};
        if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_nx_s = sync2_r;
                cnt_nx_s   = {CNT_W{1'b0}};
            end else begin
                level_nx_s = level_r;
                cnt_nx_s   = cnt_r + CNT_W'(1);
            end
        end else begin
            level_nx_s = level_r;
            cnt_nx_s   = {CNT_W{1'b0}};
        end
    end

    // Arming: require a released button before the first press is reported
    always_comb begin
        armed_nx_s   = armed_r;
        arm_cnt_nx_s = {CNT_W{1'b0}};
        if (armed_r) begin
            armed_nx_s   = 1'b1;
            arm_cnt_nx_s = {CNT_W{1'b0}};
        end else if (level_r && !level_nx_s) begin
            armed_nx_s   = 1'b1;
            arm_cnt_nx_s = {CNT_W{1'b0}};
        end else if (prime_r[1] && !sync2_r && !level_r) begin
            if (arm_cnt_r == CNT_LAST) begin
                armed_nx_s   = 1'b1;
                arm_cnt_nx_s = {CNT_W{1'b0}};
            end else begin
                armed_nx_s   = 1'b0;
                arm_cnt_nx_s = arm_cnt_r + CNT_W'(1);
            end
        end else begin
            armed_nx_s   = 1'b0;
            arm_cnt_nx_s = {CNT_W{1'b0}};
        end
    end

    // Debounce state, arming state and registered press pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            armed_r   <= 1'b0;
            arm_cnt_r <= {CNT_W{1'b0}};
            press_r   <= 1'b0;
        end else begin
            level_r   <= level_nx_s;
            level_d_r <= level_r;
            cnt_r     <= cnt_nx_s;
            armed_r   <= armed_nx_s;
            arm_cnt_r <= arm_cnt_nx_s;
            press_r   <= level_r & ~level_d_r & armed_r;
        end
    end

    assign btn_press = press_r;

endmodule

// File: rtl/game_timekeeper.sv
// ----------------------------------------------------------------------------
// game_timekeeper
// Level time keeper: counts display frames into game_time units, freezes
// after a player death, stops on the win screen, clears on the menu screen,
// and reports debounced button presses.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   btn_raw : raw push button, asynchronous, active-high
//   tk      : game_timekeeper_if.slave (frame_tick, playerDied, menuScreen,
//             winScreen in; game_time, userSel, respawning, running out)
// Input priority: menuScreen > playerDied edge > winScreen > frame_tick.
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module game_timekeeper
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned FRAMES_PER_UNIT = 6,
    parameter int unsigned RESPAWN_FRAMES  = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    game_timekeeper_if.slave tk
);

    localparam int PRESC_W = (FRAMES_PER_UNIT > 1) ? $clog2(FRAMES_PER_UNIT) : 1;
    localparam int RESP_W  = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(FRAMES_PER_UNIT - 1);
    localparam logic [RESP_W-1:0]  RESP_LAST  = RESP_W'(RESPAWN_FRAMES - 1);

    tk_state_e              state_r;
    tk_state_e              state_nx_s;
    logic [GAME_TIME_W-1:0] game_time_r;
    logic [GAME_TIME_W-1:0] time_nx_s;
    logic [PRESC_W-1:0]     presc_r;
    logic [PRESC_W-1:0]     presc_nx_s;
    logic [RESP_W-1:0]      resp_cnt_r;
    logic [RESP_W-1:0]      resp_nx_s;
    logic                   died_d_r;
    logic                   death_s;
    logic                   running_r;
    logic                   respawning_r;
    logic                   user_sel_s;

    // Button conditioning
    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_press (user_sel_s)
    );

    // A held playerDied counts once: only its rising edge kills the player
    assign death_s = tk.playerDied & ~died_d_r;

    // Next-state, time, prescaler and respawn counter
    always_comb begin
        state_nx_s = state_r;
        time_nx_s  = game_time_r;
        presc_nx_s = presc_r;
        resp_nx_s  = resp_cnt_r;
        if (tk.menuScreen) begin
            state_nx_s = TK_IDLE;
            time_nx_s  = {GAME_TIME_W{1'b0}};
            presc_nx_s = {PRESC_W{1'b0}};
            resp_nx_s  = {RESP_W{1'b0}};
        end else begin
            case (state_r)
                TK_IDLE: begin
                    time_nx_s  = {GAME_TIME_W{1'b0}};
                    presc_nx_s = {PRESC_W{1'b0}};
                    resp_nx_s  = {RESP_W{1'b0}};
                    if (!tk.winScreen) begin
                        state_nx_s = TK_RUN;
                    end else begin
                        state_nx_s = TK_IDLE;
                    end
                end
                TK_RUN: begin
                    if (death_s) begin
                        state_nx_s = TK_RESPAWN;
                        time_nx_s  = {GAME_TIME_W{1'b0}};
                        presc_nx_s = {PRESC_W{1'b0}};
                        resp_nx_s  = {RESP_W{1'b0}};
                    end else if (tk.winScreen) begin
                        state_nx_s = TK_FROZEN;
                    end else if (tk.frame_tick) begin
                        if (presc_r == PRESC_LAST) begin
                            presc_nx_s = {PRESC_W{1'b0}};
                            time_nx_s  = sat_inc_time(game_time_r);
                        end else begin
                            presc_nx_s = presc_r + PRESC_W'(1);
                        end
                    end else begin
                        state_nx_s = TK_RUN;
                    end
                end
                TK_RESPAWN: begin
                    time_nx_s  = {GAME_TIME_W{1'b0}};
                    presc_nx_s = {PRESC_W{1'b0}};
                    if (death_s) begin
                        // Dying again during the freeze restarts it
                        resp_nx_s = {RESP_W{1'b0}};
                    end else if (tk.frame_tick) begin
                        if (resp_cnt_r == RESP_LAST) begin
                            state_nx_s = TK_RUN;
                            resp_nx_s  = {RESP_W{1'b0}};
                        end else begin
                            resp_nx_s = resp_cnt_r + RESP_W'(1);
                        end
                    end else begin
                        state_nx_s = TK_RESPAWN;
                    end
                end
                TK_FROZEN: begin
                    state_nx_s = TK_FROZEN;
                end
                default: begin
                    state_nx_s = TK_IDLE;
                    time_nx_s  = {GAME_TIME_W{1'b0}};
                    presc_nx_s = {PRESC_W{1'b0}};
                    resp_nx_s  = {RESP_W{1'b0}};
                end
            endcase
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= TK_IDLE;
            game_time_r  <= {GAME_TIME_W{1'b0}};
            presc_r      <= {PRESC_W{1'b0}};
            resp_cnt_r   <= {RESP_W{1'b0}};
            died_d_r     <= 1'b0;
            running_r    <= 1'b0;
            respawning_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            game_time_r  <= time_nx_s;
            presc_r      <= presc_nx_s;
            resp_cnt_r   <= resp_nx_s;
            died_d_r     <= tk.playerDied;
            running_r    <= (state_nx_s == TK_RUN);
            respawning_r <= (state_nx_s == TK_RESPAWN);
        end
    end

    assign tk.game_time  = game_time_r;
    assign tk.userSel    = user_sel_s;
    assign tk.running    = running_r;
    assign tk.respawning = respawning_r;

endmodule

// File: tb/tb_game_timekeeper.sv
// ----------------------------------------------------------------------------
// tb_game_timekeeper
// Directed bench for game_timekeeper with DEBOUNCE_CYCLES=4,
// FRAMES_PER_UNIT=2, RESPAWN_FRAMES=3. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled at that point or on the falling edge.
// ----------------------------------------------------------------------------
module tb_game_timekeeper;

    localparam int DEB = 4;
    localparam int FPU = 2;
    localparam int RSP = 3;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic btn_raw = 1'b0;

    int checks_cnt     = 0;
    int errors_cnt     = 0;
    int cyc            = 0;
    int pulses         = 0;
    int last_pulse_cyc = -1;
    int rise_cyc       = 0;
    int pulses_snap    = 0;

    game_timekeeper_if tk_if();

    game_timekeeper #(
        .DEBOUNCE_CYCLES (DEB),
        .FRAMES_PER_UNIT (FPU),
        .RESPAWN_FRAMES  (RSP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .tk      (tk_if)
    );

    always #5 clk = ~clk;

    // Cycle counter (value k after the k-th rising edge)
    always @(posedge clk) cyc <= cyc + 1;

    // userSel pulse monitor
    always @(negedge clk) begin
        if (tk_if.userSel) begin
            pulses         <= pulses + 1;
            last_pulse_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs != exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        tk_if.frame_tick = 1'b1;
        step(n);
        tk_if.frame_tick = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tk_if.frame_tick = 1'b0;
        tk_if.playerDied = 1'b0;
        tk_if.menuScreen = 1'b1;
        tk_if.winScreen  = 1'b0;

        // Reset state
        step(2);
        check_eq("rst_game_time", int'(tk_if.game_time), 0);
        check_eq("rst_running", int'(tk_if.running), 0);
        check_eq("rst_respawning", int'(tk_if.respawning), 0);
        check_eq("rst_userSel", int'(tk_if.userSel), 0);
        reset = 1'b1;
        step(10);
        check_eq("idle_in_menu", int'(tk_if.running), 0);

        // Bouncing press: exactly one pulse, 7 cycles after the final rise
        btn_raw = 1'b1; step(2);
        btn_raw = 1'b0; step(2);
        btn_raw = 1'b1; rise_cyc = cyc;
        step(10);
        check_eq("press_pulses", pulses, 1);
        check_eq("press_latency", last_pulse_cyc - rise_cyc, 7);
        btn_raw = 1'b0;
        step(10);
        check_eq("release_no_pulse", pulses, 1);

        // Leave the menu and count frames
        tk_if.menuScreen = 1'b0;
        step(1);
        check_eq("run_entered", int'(tk_if.running), 1);
        check_eq("run_time0", int'(tk_if.game_time), 0);
        ticks(9);
        check_eq("time_after_9", int'(tk_if.game_time), 4);
        ticks(1);
        check_eq("time_after_10", int'(tk_if.game_time), 5);

        // Death coincident with frame_tick, held 4 cycles
        tk_if.playerDied = 1'b1;
        tk_if.frame_tick = 1'b1;
        step(1);
        tk_if.frame_tick = 1'b0;
        check_eq("death_time", int'(tk_if.game_time), 0);
        check_eq("death_respawning", int'(tk_if.respawning), 1);
        check_eq("death_running", int'(tk_if.running), 0);
        step(3);
        tk_if.playerDied = 1'b0;
        check_eq("held_death_respawn", int'(tk_if.respawning), 1);
        ticks(2);
        check_eq("respawn_after_2", int'(tk_if.respawning), 1);
        ticks(1);
        check_eq("respawn_end_run", int'(tk_if.running), 1);
        check_eq("respawn_end_flag", int'(tk_if.respawning), 0);
        ticks(1);
        check_eq("post_respawn_1tick", int'(tk_if.game_time), 0);
        ticks(1);
        check_eq("post_respawn_2tick", int'(tk_if.game_time), 1);

        // menuScreen beats a death edge in the same cycle
        tk_if.playerDied = 1'b1;
        tk_if.menuScreen = 1'b1;
        step(1);
        check_eq("menu_over_death_run", int'(tk_if.running), 0);
        check_eq("menu_over_death_resp", int'(tk_if.respawning), 0);
        check_eq("menu_over_death_time", int'(tk_if.game_time), 0);
        tk_if.playerDied = 1'b0;
        tk_if.menuScreen = 1'b0;
        step(1);
        check_eq("rerun", int'(tk_if.running), 1);

        // Death edge beats winScreen in the same cycle
        tk_if.winScreen  = 1'b1;
        tk_if.playerDied = 1'b1;
        step(1);
        check_eq("death_over_win", int'(tk_if.respawning), 1);
        tk_if.winScreen  = 1'b0;
        tk_if.playerDied = 1'b0;
        ticks(3);
        check_eq("respawn_done2", int'(tk_if.running), 1);

        // Win screen freezes the time at 650
        ticks(1300);
        check_eq("time_650", int'(tk_if.game_time), 650);
        tk_if.winScreen = 1'b1;
        step(1);
        check_eq("frozen_running", int'(tk_if.running), 0);
        check_eq("frozen_time", int'(tk_if.game_time), 650);
        ticks(4);
        check_eq("frozen_hold", int'(tk_if.game_time), 650);
        tk_if.menuScreen = 1'b1;
        step(1);
        check_eq("menu_clears_time", int'(tk_if.game_time), 0);
        tk_if.menuScreen = 1'b0;
        tk_if.winScreen  = 1'b0;
        step(1);
        check_eq("rerun2", int'(tk_if.running), 1);

        // Saturation at 2047
        ticks(4092);
        check_eq("time_2046", int'(tk_if.game_time), 2046);
        ticks(2);
        check_eq("time_2047", int'(tk_if.game_time), 2047);
        ticks(6);
        check_eq("time_saturated", int'(tk_if.game_time), 2047);
        check_eq("sat_running", int'(tk_if.running), 1);

        // Asynchronous reset between edges, button held through it
        btn_raw = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        check_eq("async_game_time", int'(tk_if.game_time), 0);
        check_eq("async_running", int'(tk_if.running), 0);
        check_eq("async_respawning", int'(tk_if.respawning), 0);
        check_eq("async_userSel", int'(tk_if.userSel), 0);
        pulses_snap = pulses;
        #3;
        reset = 1'b1;
        step(20);
        check_eq("no_sel_held_reset", pulses, pulses_snap);
        btn_raw = 1'b0;
        step(10);
        btn_raw = 1'b1;
        step(10);
        check_eq("press_after_reset", pulses, pulses_snap + 1);
        btn_raw = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
